// File: rtl/grey_pkg.sv
// Shared reflected-binary (grey) helpers used by the counter, the decoder and the benches.
// Functions work on a fixed maximum width; callers zero-extend in and size-cast the result back.
package grey_pkg;

  localparam int GREY_MAX_W = 32;

  localparam logic [GREY_MAX_W-1:0] GREY_ALL_ONES = {GREY_MAX_W{1'b1}};
  localparam logic [GREY_MAX_W-1:0] GREY_ZERO     = {GREY_MAX_W{1'b0}};

  function automatic logic [GREY_MAX_W-1:0] bin_to_grey(input logic [GREY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
  function automatic logic [GREY_MAX_W-1:0] grey_to_bin(input logic [GREY_MAX_W-1:0] g);
    logic [GREY_MAX_W-1:0] b;
    b[GREY_MAX_W-1] = g[GREY_MAX_W-1];
    for (int i = GREY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bintogrey_cnt.sv
// Registered binary up/down counter with a registered grey-code copy and a rollover pulse.
// The grey register is fed from the next binary value so bin and grey update on the same edge.
module bintogrey_cnt
  import grey_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] grey,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TC_ONES = WIDTH'(GREY_ALL_ONES);
  localparam logic [WIDTH-1:0] TC_ZERO = WIDTH'(GREY_ZERO);
  localparam logic [WIDTH-1:0] STEP    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] grey_r;
  logic             wrap_r;
  logic [WIDTH-1:0] bin_next_s;
  logic [WIDTH-1:0] grey_next_s;
  logic             wrap_next_s;

  // Next-state: load beats count beats hold; wrap flags only a counting rollover.
  always_comb begin
    bin_next_s  = bin_r;
    wrap_next_s = 1'b0;
    if (load) begin
      bin_next_s  = load_bin;
      wrap_next_s = 1'b0;
    end else if (en) begin
      if (up) begin
        bin_next_s  = bin_r + STEP;
        wrap_next_s = (bin_r == TC_ONES);
      end else begin
        bin_next_s  = bin_r - STEP;
        wrap_next_s = (bin_r == TC_ZERO);
      end
    end else begin
      bin_next_s  = bin_r;
      wrap_next_s = 1'b0;
    end
    grey_next_s = WIDTH'(bin_to_grey(GREY_MAX_W'(bin_next_s)));
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r  <= TC_ZERO;
      grey_r <= TC_ZERO;
      wrap_r <= 1'b0;
    end else begin
      bin_r  <= bin_next_s;
      grey_r <= grey_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign bin  = bin_r;
  assign grey = grey_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_bintogrey_cnt.sv
// Directed table-driven bench for bintogrey_cnt (WIDTH=4), with hand-computed expectations,
// a grey-to-binary decoder cross-check, single-bit-change checks and async-reset sequences.
module tb_bintogrey_cnt;
  import grey_pkg::*;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] load_bin;
    logic [3:0] exp_bin;
    logic [3:0] exp_grey;
    logic       exp_wrap;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_bin;
  logic [3:0] bin;
  logic [3:0] grey;
  logic       wrap;

  int n_vec;
  int n_err;
  vec_t vecs[$];

  bintogrey_cnt #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .grey     (grey),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic e, input logic u, input logic [3:0] lb,
                     input logic [3:0] eb, input logic [3:0] eg, input logic ew);
    vec_t v;
    v.load = ld; v.en = e; v.up = u; v.load_bin = lb;
    v.exp_bin = eb; v.exp_grey = eg; v.exp_wrap = ew;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] up_grey [16];
    logic [3:0] prev_grey;
    logic [31:0] dec;

    n_vec = 0;
    n_err = 0;
    up_grey = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // count up 16 steps from 0: wrap only on 1111 -> 0000
    for (int i = 0; i < 16; i++) begin
      add(1'b0, 1'b1, 1'b1, 4'h0, 4'(i + 1), up_grey[i], (i == 15));
    end
    // count down through zero
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'hE, 4'h9, 1'b0);
    // load wins over count; loading a terminal value never wraps
    add(1'b1, 1'b1, 1'b1, 4'hB, 4'hB, 4'hE, 1'b0);
    add(1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 4'h8, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'h5, 4'h5, 4'h7, 1'b0);
    // hold three cycles, then up/down/up with no turnaround
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'h5, 4'h7, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'h0, 4'h5, 4'h7, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'h5, 4'h7, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h6, 4'h5, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 4'h7, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h6, 4'h5, 1'b0);

    // asynchronous reset with no edge in between
    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = 4'h0;
    #2;
    check("reset_bin",  32'(bin),  32'h0);
    check("reset_grey", 32'(grey), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    prev_grey = 4'h0;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      load = vecs[i].load; en = vecs[i].en; up = vecs[i].up; load_bin = vecs[i].load_bin;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_bin", i),  32'(bin),  32'(vecs[i].exp_bin));
      check($sformatf("v%0d_grey", i), 32'(grey), 32'(vecs[i].exp_grey));
      check($sformatf("v%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
      dec = grey_to_bin(32'(grey));
      check($sformatf("v%0d_decode", i), dec, 32'(vecs[i].exp_bin));
      if (!vecs[i].load && vecs[i].en) begin
        check($sformatf("v%0d_onebit", i), 32'($countones(grey ^ prev_grey)), 32'd1);
      end
      prev_grey = grey;
    end

    // reset mid-operation while a wrap pulse is high
    @(negedge clk);
    load = 1'b1; load_bin = 4'hF; en = 1'b0;
    @(posedge clk);
    #1;
    check("pre_load_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1;
    @(posedge clk);
    #1;
    check("roll_wrap", 32'(wrap), 32'h1);
    check("roll_bin",  32'(bin),  32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wrap", 32'(wrap), 32'h0);
    check("midrst_bin",  32'(bin),  32'h0);
    check("midrst_grey", 32'(grey), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_bin",  32'(bin),  32'h1);
    check("release_grey", 32'(grey), 32'h1);
    check("release_wrap", 32'(wrap), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bintogrey_cnt.md
# bintogrey_cnt

Registered binary-to-grey up/down counter, the encoding counterpart of the grey-to-binary decoder. It keeps a binary count and presents it in reflected binary (grey) code, so each step changes exactly one `grey` bit. It is the pointer source for async FIFOs and clock-crossing position counters, with the existing grey-to-binary decoder at the far end. Both output codes come from registers, so no combinational logic drives `grey`.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; steps the counter once per cycle while high.
- `up`  in  1  direction: 1 = increment, 0 = decrement; sampled only when `en`=1.
- `load`  in  1  synchronous load of `load_bin`.
- `load_bin`  in  WIDTH  binary value to load.
- `bin`  out  WIDTH  registered binary count.
- `grey`  out  WIDTH  registered grey code of `bin`; always equals `bin ^ (bin >> 1)`.
- `wrap`  out  1  registered one-cycle pulse on terminal-count rollover.

## Operation
- Reset (`rst_n`=0, asynchronous, no clock needed): `bin`=0, `grey`=0, `wrap`=0. All three hold these values while `rst_n` is low.
- Per-cycle priority is `load` > `en` > hold:
  - `load`=1: `bin`←`load_bin` and `grey`←bin_to_grey(`load_bin`). `wrap`←0. `en` and `up` are ignored.
  - `en`=1, `up`=1: `bin`←`bin`+1, modulo 2^WIDTH.
  - `en`=1, `up`=0: `bin`←`bin`−1, modulo 2^WIDTH.
  - Otherwise: `bin` and `grey` hold, and `wrap`←0.
- `grey` register input = bin_to_grey(next `bin`). `grey` is never derived from the registered `bin` through logic after the flop, so both outputs change on the same edge.
- Arithmetic is WIDTH bits. Overflow and underflow wrap silently, with no saturation.
- `wrap`←1 for exactly one cycle when a counting step rolls over:
  - up: `bin`=all-ones → 0.
  - down: `bin`=0 → all-ones.
- A load never asserts `wrap`, even when the loaded value is a terminal value.
- With `en` held high for 2^WIDTH cycles, `wrap` pulses exactly once per full cycle of the count.
- Every counting step changes exactly one `grey` bit, including at rollover. A load may change any number of bits; the consumer owns the crossing hazard for loads.
- Releasing reset: the first edge with `rst_n`=1 is evaluated normally. A count or load requested on that edge takes effect.

## Timing
- Latency is one cycle from inputs to outputs: `load`/`en` sampled at edge N are visible on `bin`/`grey`/`wrap` after edge N.
- No combinational path from any input to any output.
- There is no handshake. `en` is level-sensitive, so one step occurs per enabled cycle.
- Direction reversal (`up` toggled while `en` stays high) needs no turnaround cycle. Example: 5 → 6 → 5 on consecutive edges.
- Reset asserted mid-count clears the outputs immediately, without waiting for an edge. A `wrap` pulse in flight is cut short.

## Structure
- Shared package `grey_pkg` holds:
  - function `bin_to_grey(logic [WIDTH-1:0])`, returning `b ^ (b >> 1)`;
  - the matching function `grey_to_bin`, so encoder, decoder and benches share one definition;
  - localparams for the all-ones and zero terminal values.
- No sub-module: one always_ff block for state, plus next-state logic.
- Reuse the existing grey-to-binary decoder only in the bench, as a cross-check.

## Test plan
- Reset: pulse `rst_n` low between edges with no clock running → `bin`=0000, `grey`=0000, `wrap`=0 immediately.
- Count up, `en`=1 `up`=1 for 16 cycles from 0 → `grey` sequence 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000. `wrap`=1 only on the 1000→0000 cycle. Every step has Hamming distance 1. The decoder returns `bin` on every cycle.
- Count down from 0, `up`=0, `en`=1 → `bin`=1111, `grey`=1000, `wrap`=1 for one cycle. The next step gives `bin`=1110, `grey`=1001, `wrap`=0.
- Load with `load`=1, `load_bin`=1011, `en`=1 in the same cycle → next cycle `bin`=1011, `grey`=1110, `wrap`=0. Then load 1111 → `wrap` stays 0.
- Hold and reverse: `en`=0 for 3 cycles at `bin`=0101 → outputs unchanged. Then up, down, up → `bin` goes 0110, 0101, 0110 and `grey` goes 0101, 0111, 0101.
- Reset mid-operation: assert `rst_n` low while `wrap`=1 → `wrap` drops and outputs read 0 before the next edge. Deassert `rst_n` with `en`=1 → first edge gives `bin`=0001.
